// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FSM state encodings for uart_fifo_ctrl.
package uart_pkg;

    typedef enum logic [1:0] {
        REG_CLK_DIV = 2'd0,
        REG_STATUS  = 2'd1,
        REG_DATA    = 2'd2,
        REG_CTRL    = 2'd3
    } reg_off_e;

    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_IDLE      = 2;
    localparam int ST_OVERRUN      = 3;
    localparam int ST_FRAME_ERR    = 4;

    localparam int CT_TWO_STOP  = 0;
    localparam int CT_LOOPBACK  = 1;
    localparam int CT_RX_IRQ_EN = 8;
    localparam int CT_TX_IRQ_EN = 9;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, registered storage, combinational head; push/pop take effect at the clock edge.
// Push into a full FIFO is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// MMIO UART (8N1/8N2) with RX/TX FIFOs, sticky errors, loopback; reads combinational, TX FIFO drops when full.
// Interrupt output and CTRL[9:8] exist only when UART_IRQ_EN is defined; otherwise irq_out is tied low.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int          RX_DEPTH        = 16,
    parameter int          TX_DEPTH        = 16,
    parameter logic [15:0] DEFAULT_CLK_DIV = 16'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_in,
    output logic        tx_out,
    input  logic        sel_in,
    input  logic        read_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        irq_out
);
    logic [15:0] r_clk_div;
    logic        r_two_stop, r_loopback, r_overrun, r_frame_err;
    logic [1:0]  r_rx_sync;
    rx_state_e   r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    tx_state_e   r_tx_state;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx_stop2, r_tx_out;

    reg_off_e    w_reg;
    logic        w_rx_bit, w_rx_push, w_rx_ferr, w_rx_pop, w_rx_full, w_rx_empty;
    logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_idle;
    logic        w_rx_irq_en, w_tx_irq_en;
    logic [7:0]  w_rx_head, w_tx_head;
    logic [4:0]  w_status;
    logic [31:0] w_rdata;
    logic [$clog2(RX_DEPTH+1)-1:0] w_rx_count;
    logic [$clog2(TX_DEPTH+1)-1:0] w_tx_count;
    logic        w_unused_bits;

    assign w_reg     = reg_off_e'(address_in[3:2]);
    assign w_rx_bit  = r_rx_sync[1];
    assign w_rx_pop  = sel_in && read_in && (w_reg == REG_DATA);
    assign w_tx_push = sel_in && write_mask_in[0] && (w_reg == REG_DATA);
    assign w_rx_push = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && w_rx_bit;
    assign w_rx_ferr = (r_rx_state == RX_STOP) && (r_rx_cnt == '0) && !w_rx_bit;
    // STOP->START hand-off pops here too, so back-to-back bytes leave no idle gap.
    assign w_tx_pop  = !w_tx_empty && ((r_tx_state == TX_IDLE) ||
                       ((r_tx_state == TX_STOP) && (r_tx_cnt == '0) && !r_tx_stop2));
    assign w_tx_idle = w_tx_empty && (r_tx_state == TX_IDLE);
    assign w_status  = {r_frame_err, r_overrun, w_tx_idle, !w_rx_empty, !w_tx_full};
    assign tx_out    = r_tx_out;
    assign w_unused_bits = ^{address_in[31:4], address_in[1:0], write_value_in[31:16],
                             write_mask_in[3:2], w_rx_count, w_tx_count};

    uart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .i_push(w_rx_push), .i_push_dat(r_rx_shift), .i_pop(w_rx_pop),
        .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count), .o_head(w_rx_head)
    );

    uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .i_push(w_tx_push), .i_push_dat(write_value_in[7:0]), .i_pop(w_tx_pop),
        .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count), .o_head(w_tx_head)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_clk_div   <= DEFAULT_CLK_DIV;
            r_two_stop  <= 1'b0;
            r_loopback  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (sel_in && (w_reg == REG_CLK_DIV) && write_mask_in[0]) r_clk_div[7:0]  <= write_value_in[7:0];
            if (sel_in && (w_reg == REG_CLK_DIV) && write_mask_in[1]) r_clk_div[15:8] <= write_value_in[15:8];
            if (sel_in && (w_reg == REG_CTRL) && write_mask_in[0]) begin
                r_two_stop <= write_value_in[CT_TWO_STOP];
                r_loopback <= write_value_in[CT_LOOPBACK];
            end
            if (sel_in && (w_reg == REG_STATUS) && write_mask_in[0]) begin
                if (write_value_in[ST_OVERRUN])   r_overrun   <= 1'b0;
                if (write_value_in[ST_FRAME_ERR]) r_frame_err <= 1'b0;
            end
            // A new error in the same cycle as a clear wins, so no event is lost.
            if (w_rx_push && w_rx_full && !w_rx_pop) r_overrun   <= 1'b1;
            if (w_rx_ferr)                           r_frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_sync  <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], r_loopback ? r_tx_out : rx_in};
            if (r_rx_cnt != '0) r_rx_cnt <= r_rx_cnt - 16'd1;
            case (r_rx_state)
                RX_IDLE: if (!w_rx_bit) begin
                    r_rx_state <= RX_START;
                    r_rx_cnt   <= r_clk_div >> 1;
                end
                RX_START: if (r_rx_cnt == '0) begin
                    r_rx_state <= w_rx_bit ? RX_IDLE : RX_DATA;
                    r_rx_cnt   <= r_clk_div;
                    r_rx_bit   <= '0;
                end
                RX_DATA: if (r_rx_cnt == '0) begin
                    r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
                    r_rx_cnt   <= r_clk_div;
                    r_rx_bit   <= r_rx_bit + 3'd1;
                    if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                end
                RX_STOP: if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_stop2 <= 1'b0;
            r_tx_out   <= 1'b1;
        end else begin
            if (r_tx_cnt != '0) r_tx_cnt <= r_tx_cnt - 16'd1;
            case (r_tx_state)
                TX_IDLE: if (!w_tx_empty) begin
                    r_tx_state <= TX_START;
                    r_tx_shift <= w_tx_head;
                    r_tx_cnt   <= r_clk_div;
                    r_tx_out   <= 1'b0;
                end
                TX_START: if (r_tx_cnt == '0) begin
                    r_tx_state <= TX_DATA;
                    r_tx_cnt   <= r_clk_div;
                    r_tx_bit   <= '0;
                    r_tx_out   <= r_tx_shift[0];
                end
                TX_DATA: if (r_tx_cnt == '0) begin
                    r_tx_cnt <= r_clk_div;
                    if (r_tx_bit == 3'd7) begin
                        r_tx_state <= TX_STOP;
                        r_tx_stop2 <= r_two_stop;
                        r_tx_out   <= 1'b1;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_out   <= r_tx_shift[1];
                    end
                end
                TX_STOP: if (r_tx_cnt == '0) begin
                    r_tx_cnt <= r_clk_div;
                    if (r_tx_stop2) begin
                        r_tx_stop2 <= 1'b0;
                    end else if (!w_tx_empty) begin
                        r_tx_state <= TX_START;
                        r_tx_shift <= w_tx_head;
                        r_tx_out   <= 1'b0;
                    end else begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef UART_IRQ_EN
    logic r_rx_irq_en, r_tx_irq_en, r_irq;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_irq_en <= 1'b0;
            r_tx_irq_en <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (sel_in && (w_reg == REG_CTRL) && write_mask_in[1]) begin
                r_rx_irq_en <= write_value_in[CT_RX_IRQ_EN];
                r_tx_irq_en <= write_value_in[CT_TX_IRQ_EN];
            end
            r_irq <= (r_rx_irq_en && (!w_rx_empty || r_overrun || r_frame_err)) ||
                     (r_tx_irq_en && w_tx_idle);
        end
    end

    assign w_rx_irq_en = r_rx_irq_en;
    assign w_tx_irq_en = r_tx_irq_en;
    assign irq_out     = r_irq;
`else
    assign w_rx_irq_en = 1'b0;
    assign w_tx_irq_en = 1'b0;
    assign irq_out     = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_CLK_DIV: w_rdata[15:0] = r_clk_div;
            REG_STATUS:  w_rdata[4:0]  = w_status;
            REG_DATA:    w_rdata       = w_rx_empty ? 32'hFFFF_FFFF : {24'b0, w_rx_head};
            REG_CTRL: begin
                w_rdata[CT_TWO_STOP]  = r_two_stop;
                w_rdata[CT_LOOPBACK]  = r_loopback;
                w_rdata[CT_RX_IRQ_EN] = w_rx_irq_en;
                w_rdata[CT_TX_IRQ_EN] = w_tx_irq_en;
            end
            default: w_rdata = '0;
        endcase
        read_value_out = sel_in ? w_rdata : 32'd0;
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: register map, TX framing, loopback, overrun, frame error, reset, irq.
module tb_uart_fifo_ctrl;
    localparam int          RXD     = 4;
    localparam int          TXD     = 4;
    localparam logic [15:0] DEF_DIV = 16'd5;
    localparam logic [31:0] A_CLK   = 32'h0;
    localparam logic [31:0] A_STAT  = 32'h4;
    localparam logic [31:0] A_DATA  = 32'h8;
    localparam logic [31:0] A_CTRL  = 32'hC;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_in = 1'b1;
    logic        tx_out;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [3:0]  write_mask_in = 4'h0;
    logic [31:0] address_in = 32'h0;
    logic [31:0] write_value_in = 32'h0;
    logic [31:0] read_value_out;
    logic        irq_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [89:0]  rec;
    logic [89:0]  exp_w;
    logic [119:0] ne_hist;
    logic [119:0] irq_hist;
    logic [7:0]   tx_bytes [2];
    logic [7:0]   rx_bytes [5];
    logic [7:0]   cur;
    int           idx;
    int           t_ne;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.RX_DEPTH(RXD), .TX_DEPTH(TXD), .DEFAULT_CLK_DIV(DEF_DIV)) dut (
        .clk(clk), .reset_n(reset_n), .rx_in(rx_in), .tx_out(tx_out),
        .sel_in(sel_in), .read_in(read_in), .write_mask_in(write_mask_in),
        .address_in(address_in), .write_value_in(write_value_in),
        .read_value_out(read_value_out), .irq_out(irq_out)
    );

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input logic [3:0] mask);
        @(negedge clk);
        sel_in = 1'b1; address_in = addr; write_value_in = val; write_mask_in = mask;
        @(negedge clk);
        sel_in = 1'b0; write_mask_in = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        sel_in = 1'b1; read_in = 1'b1; address_in = addr;
        #1 data = read_value_out;
        @(negedge clk);
        sel_in = 1'b0; read_in = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_read(addr, rd);
        chk(tag, rd, exp);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_lvl, input int bitc);
        logic [9:0] sym;
        sym = {stop_lvl, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_in = sym[i];
            repeat (bitc) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (2 * bitc) @(negedge clk);
    endtask

    initial begin
        tx_bytes[0] = 8'h55; tx_bytes[1] = 8'hA3;
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h5A;
        rx_bytes[3] = 8'hC3; rx_bytes[4] = 8'h7E;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_tx_out", tx_out, 1);
        chk("rst_irq", irq_out, 0);
        chk("rd_nosel", read_value_out, 0);
        chk_reg("rst_clkdiv", A_CLK, {16'h0, DEF_DIV});
        chk_reg("rst_status", A_STAT, 32'h05);
        chk_reg("rst_ctrl", A_CTRL, 32'h0);
        chk_reg("rst_data", A_DATA, 32'hFFFF_FFFF);

        // byte-masked CLK_DIV writes, then two back-to-back TX frames at 4 cycles/bit
        bus_write(A_CLK, 32'h0000_1200, 4'b0010);
        chk_reg("clkdiv_b1", A_CLK, 32'h1205);
        bus_write(A_CLK, 32'hFFFF_0003, 4'b0011);
        chk_reg("clkdiv_set3", A_CLK, 32'h3);
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (c < 2) begin
                sel_in = 1'b1; address_in = A_DATA; write_mask_in = 4'b0001;
                write_value_in = (c == 0) ? 32'h55 : 32'hA3;
            end else begin
                sel_in = 1'b0; write_mask_in = 4'h0;
            end
            #1 rec[c] = tx_out;
        end
        exp_w = '1;
        idx = 2;
        for (int f = 0; f < 2; f++) begin
            cur = tx_bytes[f];
            for (int k = 0; k < 4; k++) begin exp_w[idx] = 1'b0; idx++; end
            for (int b = 0; b < 8; b++)
                for (int k = 0; k < 4; k++) begin exp_w[idx] = cur[b]; idx++; end
            for (int k = 0; k < 4; k++) begin exp_w[idx] = 1'b1; idx++; end
        end
        chk("tx_wave", rec, exp_w);
        chk_reg("tx_done_status", A_STAT, 32'h05);

        // loopback at 8 cycles/bit
        bus_write(A_CLK, 32'h7, 4'b0001);
        bus_write(A_CTRL, 32'h2, 4'b0001);
        chk_reg("ctrl_lb", A_CTRL, 32'h2);
        bus_write(A_DATA, 32'h3C, 4'b0001);
        repeat (130) @(negedge clk);
        chk_reg("lb_status", A_STAT, 32'h07);
        chk_reg("lb_data", A_DATA, 32'h3C);
        chk_reg("lb_empty", A_DATA, 32'hFFFF_FFFF);
        bus_write(A_CTRL, 32'h0, 4'b0001);

        // RX_DEPTH+1 frames with no reads: last one overruns
        for (int i = 0; i < 5; i++) send_rx(rx_bytes[i], 1'b1, 8);
        chk_reg("ovr_status", A_STAT, 32'h0F);
        bus_write(A_STAT, 32'h08, 4'b0001);
        chk_reg("ovr_clear", A_STAT, 32'h07);
        for (int i = 0; i < 4; i++) chk_reg($sformatf("ovr_data%0d", i), A_DATA, {24'h0, rx_bytes[i]});
        chk_reg("ovr_empty", A_DATA, 32'hFFFF_FFFF);

        // stop bit low, then a short glitch
        send_rx(8'hA5, 1'b0, 8);
        repeat (16) @(negedge clk);
        chk_reg("ferr_status", A_STAT, 32'h15);
        bus_write(A_STAT, 32'h10, 4'b0001);
        chk_reg("ferr_clear", A_STAT, 32'h05);
        @(negedge clk) rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        chk_reg("glitch_status", A_STAT, 32'h05);

        // reset in the middle of data bit 1 of 0xF0
        bus_write(A_CTRL, 32'h1, 4'b0001);
        bus_write(A_DATA, 32'hF0, 4'b0001);
        repeat (18) @(negedge clk);
        #1 chk("pre_rst_tx", tx_out, 0);
        reset_n = 1'b0;
        @(negedge clk);
        #1 chk("rst_mid_tx", tx_out, 1);
        reset_n = 1'b1;
        chk_reg("rst2_status", A_STAT, 32'h05);
        chk_reg("rst2_ctrl", A_CTRL, 32'h0);
        chk_reg("rst2_clkdiv", A_CLK, {16'h0, DEF_DIV});

        // receive 0x81 at the default divider, watching rx_not_empty and irq_out
`ifdef UART_IRQ_EN
        bus_write(A_CTRL, 32'h100, 4'b0010);
        chk_reg("ctrl_irq", A_CTRL, 32'h100);
`else
        bus_write(A_CTRL, 32'h301, 4'b0011);
        chk_reg("ctrl_noirq", A_CTRL, 32'h001);
`endif
        sel_in = 1'b1; read_in = 1'b0; address_in = A_STAT;
        fork
            send_rx(8'h81, 1'b1, 6);
            for (int c = 0; c < 120; c++) begin
                @(negedge clk);
                #1 ne_hist[c] = read_value_out[1];
                irq_hist[c] = irq_out;
            end
        join
        sel_in = 1'b0;
        t_ne = -1;
        for (int c = 0; c < 120; c++) if (t_ne < 0 && ne_hist[c]) t_ne = c;
        chk("rx81_seen", (t_ne >= 0 && t_ne < 119), 1);
`ifdef UART_IRQ_EN
        if (t_ne >= 0 && t_ne < 119) begin
            chk("irq_at_push", irq_hist[t_ne], 0);
            chk("irq_after_push", irq_hist[t_ne+1], 1);
        end
`else
        chk("irq_tied", |irq_hist, 0);
`endif
        chk_reg("rx81_data", A_DATA, 32'h81);
`ifdef UART_IRQ_EN
        #1 chk("irq_after_pop", irq_out, 1);
        @(negedge clk);
        #1 chk("irq_fall", irq_out, 0);
`else
        #1 chk("irq_low_end", irq_out, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
